mem_controller: RTL and testbench

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mem_controller.sv | 187 ++++++++++++++++++
 tb/tb_mem_controller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// Memory controller: arbitrates NUM_CONSUMERS load/store-unit request ports
// onto a single memory port with one transaction in flight at a time.
// Consumers are scanned round-robin starting after the last one served; within
// a consumer a read request takes precedence over a write request. Every output
// is driven from a register.
module mem_controller #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                               clock,
    input  logic                               reset,

    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,

    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,

    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                state;
    logic [IDX_BITS-1:0]   current_consumer;
    logic [IDX_BITS-1:0]   last_granted;

    // Per-consumer views of the flattened buses.
    logic [ADDR_BITS-1:0]  read_addr   [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]  write_addr  [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]  write_data  [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]  read_data_q [NUM_CONSUMERS];

    for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_slices
        assign read_addr[g]  = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
        assign write_addr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
        assign write_data[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = read_data_q[g];
    end

    // Round-robin scan result, only consumed while the FSM is IDLE.
    logic                  scan_found;
    logic                  scan_is_read;
    logic [IDX_BITS-1:0]   scan_idx;
    logic [IDX_BITS:0]     cand_sum;
    logic [IDX_BITS-1:0]   cand;

    // Find the first requesting consumer after last_granted, read before write.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        scan_found   = 1'b0;
        scan_is_read = 1'b0;
        scan_idx     = '0;
        cand_sum     = '0;
        cand         = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand_sum = {1'b0, last_granted} + (IDX_BITS+1)'(k + 1);
            if (cand_sum >= (IDX_BITS+1)'(NUM_CONSUMERS)) begin
                cand_sum = cand_sum - (IDX_BITS+1)'(NUM_CONSUMERS);
            end
            cand = cand_sum[IDX_BITS-1:0];
            if (!scan_found) begin
                if (consumer_read_valid[cand]) begin
                    scan_found   = 1'b1;
                    scan_is_read = 1'b1;
                    scan_idx     = cand;
                end else if (consumer_write_valid[cand]) begin
                    scan_found   = 1'b1;
                    scan_is_read = 1'b0;
                    scan_idx     = cand;
                end
            end
        end
    end

    // Transaction FSM with all outputs registered alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            current_consumer     <= '0;
            last_granted         <= IDX_BITS'(NUM_CONSUMERS - 1);
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            // NOTE: the read-data slots are output registers, not a RAM, so
            // they are cleared with everything else on reset.
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                read_data_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (scan_found) begin
                        current_consumer <= scan_idx;
                        if (scan_is_read) begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= read_addr[scan_idx];
                            state            <= READ_WAITING;
                        end else begin
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= write_addr[scan_idx];
                            mem_write_data    <= write_data[scan_idx];
                            state             <= WRITE_WAITING;
                        end
                    end
                end

                READ_WAITING: begin
                    if (mem_read_ready) begin
                        mem_read_valid <= 1'b0;
                        if (consumer_read_valid[current_consumer]) begin
                            read_data_q[current_consumer]         <= mem_read_data;
                            consumer_read_ready[current_consumer] <= 1'b1;
                            state                                 <= READ_RELAYING;
                        end else begin
                            // Consumer withdrew: finish quietly and move on.
                            last_granted <= current_consumer;
                            state        <= IDLE;
                        end
                    end
                end

                WRITE_WAITING: begin
                    if (mem_write_ready) begin
                        mem_write_valid <= 1'b0;
                        if (consumer_write_valid[current_consumer]) begin
                            consumer_write_ready[current_consumer] <= 1'b1;
                            state                                  <= WRITE_RELAYING;
                        end else begin
                            last_granted <= current_consumer;
                            state        <= IDLE;
                        end
                    end
                end

                READ_RELAYING: begin
                    if (!consumer_read_valid[current_consumer]) begin
                        consumer_read_ready[current_consumer] <= 1'b0;
                        last_granted                          <= current_consumer;
                        state                                 <= IDLE;
                    end
                end

                WRITE_RELAYING: begin
                    if (!consumer_write_valid[current_consumer]) begin
                        consumer_write_ready[current_consumer] <= 1'b0;
                        last_granted                           <= current_consumer;
                        state                                  <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Testbench for mem_controller: directed scenarios followed by randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_mem_controller;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic              clock = 1'b0;
    logic              reset;

    logic [N-1:0]      rv, wv;
    logic [AW-1:0]     ra [N];
    logic [AW-1:0]     wa [N];
    logic [DW-1:0]     wd [N];
    logic [N*AW-1:0]   ra_flat, wa_flat;
    logic [N*DW-1:0]   wd_flat;
    logic [N-1:0]      rrdy, wrdy;
    logic [N*DW-1:0]   rdata_flat;

    logic              mrv, mrr, mwv, mwr;
    logic [AW-1:0]     mra, mwa;
    logic [DW-1:0]     mrd, mwd;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign ra_flat[g*AW +: AW] = ra[g];
        assign wa_flat[g*AW +: AW] = wa[g];
        assign wd_flat[g*DW +: DW] = wd[g];
    end

    mem_controller #(
        .NUM_CONSUMERS (N),
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .consumer_read_valid    (rv),
        .consumer_read_address  (ra_flat),
        .consumer_read_ready    (rrdy),
        .consumer_read_data     (rdata_flat),
        .consumer_write_valid   (wv),
        .consumer_write_address (wa_flat),
        .consumer_write_data    (wd_flat),
        .consumer_write_ready   (wrdy),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transaction view: is someone being served, which kind, who, and has the
    // answer been handed back yet.
    bit            m_busy, m_delivered, m_read;
    int            m_who, m_last;
    logic          e_mrv, e_mwv;
    logic [AW-1:0] e_mra, e_mwa;
    logic [DW-1:0] e_mwd;
    logic [N-1:0]  e_rrdy, e_wrdy;
    logic [DW-1:0] e_rdata [N];

    // Returns 2*consumer for a read grant, 2*consumer+1 for a write, -1 if none.
    function automatic int next_grant(input logic [N-1:0] r, input logic [N-1:0] w, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return 2 * c;
            if (w[c]) return 2 * c + 1;
        end
        return -1;
    endfunction

    int pick;
    always_comb pick = next_grant(rv, wv, m_last);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_delivered <= 1'b0; m_read <= 1'b0;
            m_who <= 0; m_last <= N - 1;
            e_mrv <= 1'b0; e_mwv <= 1'b0; e_mra <= '0; e_mwa <= '0; e_mwd <= '0;
            e_rrdy <= '0; e_wrdy <= '0;
            for (int i = 0; i < N; i++) e_rdata[i] <= '0;
        end else if (!m_busy) begin
            if (pick >= 0) begin
                m_busy <= 1'b1;
                m_who  <= pick / 2;
                m_read <= (pick % 2 == 0);
                if (pick % 2 == 0) begin
                    e_mrv <= 1'b1; e_mra <= ra[pick/2];
                end else begin
                    e_mwv <= 1'b1; e_mwa <= wa[pick/2]; e_mwd <= wd[pick/2];
                end
            end
        end else if (!m_delivered) begin
            if (m_read && mrr) begin
                e_mrv <= 1'b0;
                if (rv[m_who]) begin
                    e_rrdy[m_who] <= 1'b1; e_rdata[m_who] <= mrd; m_delivered <= 1'b1;
                end else begin
                    m_busy <= 1'b0; m_last <= m_who;
                end
            end else if (!m_read && mwr) begin
                e_mwv <= 1'b0;
                if (wv[m_who]) begin
                    e_wrdy[m_who] <= 1'b1; m_delivered <= 1'b1;
                end else begin
                    m_busy <= 1'b0; m_last <= m_who;
                end
            end
        end else if (m_read ? !rv[m_who] : !wv[m_who]) begin
            e_rrdy <= '0; e_wrdy <= '0;
            m_busy <= 1'b0; m_delivered <= 1'b0; m_last <= m_who;
        end
    end

    // ---------------- per-cycle compare ----------------
    task automatic compare_all();
        check("mem_read_valid", mrv, e_mrv);
        check("mem_read_address", mra, e_mra);
        check("mem_write_valid", mwv, e_mwv);
        check("mem_write_address", mwa, e_mwa);
        check("mem_write_data", mwd, e_mwd);
        check("consumer_read_ready", rrdy, e_rrdy);
        check("consumer_write_ready", wrdy, e_wrdy);
        for (int i = 0; i < N; i++)
            check($sformatf("consumer_read_data[%0d]", i), rdata_flat[i*DW +: DW], e_rdata[i]);
        check("mem_valids_exclusive", mrv & mwv, 1'b0);
        check("ready_at_most_one", ($countones({rrdy, wrdy}) <= 1), 1'b1);
    endtask

    task automatic step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic wait_read_grant();
        int n = 0;
        while (mrv !== 1'b1 && n < 20) begin step(); n++; end
        check("read_grant_seen", mrv, 1'b1);
    endtask

    task automatic wait_write_grant();
        int n = 0;
        while (mwv !== 1'b1 && n < 20) begin step(); n++; end
        check("write_grant_seen", mwv, 1'b1);
    endtask

    task automatic reply_read(input logic [DW-1:0] d, input int delay);
        repeat (delay) step();
        mrr = 1'b1; mrd = d;
        step();
        mrr = 1'b0; mrd = DW'($urandom);
    endtask

    task automatic reply_write(input int delay);
        repeat (delay) step();
        mwr = 1'b1;
        step();
        mwr = 1'b0;
    endtask

    task automatic randomize_inputs();
        mrr = ($urandom_range(3) == 0); mrd = DW'($urandom);
        mwr = ($urandom_range(3) == 0);
        for (int i = 0; i < N; i++) begin
            if (rv[i]) begin
                if (rrdy[i]) begin
                    if ($urandom_range(1) == 0) rv[i] = 1'b0;
                end else if ($urandom_range(31) == 0) rv[i] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                rv[i] = 1'b1; ra[i] = AW'($urandom);
            end
            if (wv[i]) begin
                if (wrdy[i]) begin
                    if ($urandom_range(1) == 0) wv[i] = 1'b0;
                end else if ($urandom_range(31) == 0) wv[i] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                wv[i] = 1'b1; wa[i] = AW'($urandom); wd[i] = DW'($urandom);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        rv = '0; wv = '0; mrr = 1'b0; mwr = 1'b0; mrd = '0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; wa[i] = '0; wd[i] = '0; end
        step(); step();
        check("reset_read_valid", mrv, 1'b0);
        check("reset_readies", {rrdy, wrdy}, '0);
        check("reset_read_data", rdata_flat, '0);
        #2 reset = 1'b1;

        // Contention: all four read, grants 0,1,2,3 then 0 again.
        for (int i = 0; i < N; i++) ra[i] = AW'(8'h40 + i);
        rv = 4'hF;
        for (int k = 0; k < N; k++) begin
            wait_read_grant();
            check("contention_grant_addr", mra, 8'h40 + k);
            reply_read(DW'(8'h10 + k), 0);
            check("contention_ready", rrdy, 4'b0001 << k);
            rv[k] = 1'b0;
            step();
        end
        rv = 4'hF;
        wait_read_grant();
        check("contention_wrap_to_0", mra, 8'h40);
        reply_read(8'h20, 1);
        rv = '0;
        step();

        // Single read by consumer 2 with a 3-cycle memory latency.
        ra[2] = 8'h3C; rv[2] = 1'b1;
        wait_read_grant();
        check("single_read_addr", mra, 8'h3C);
        reply_read(8'hA5, 3);
        check("single_read_ready", rrdy, 4'b0100);
        check("single_read_data", rdata_flat[2*DW +: DW], 8'hA5);
        step(); step();
        check("single_read_ready_held", rrdy, 4'b0100);
        check("other_slice_held", rdata_flat[1*DW +: DW], 8'h11);
        rv[2] = 1'b0;
        step();
        check("single_read_ready_drop", rrdy, 4'b0000);

        // Single write by consumer 1.
        wa[1] = 8'h10; wd[1] = 8'h7E; wv[1] = 1'b1;
        wait_write_grant();
        check("single_write_addr", mwa, 8'h10);
        check("single_write_data", mwd, 8'h7E);
        reply_write(2);
        check("single_write_ready", wrdy, 4'b0010);
        wv[1] = 1'b0;
        step();
        check("single_write_ready_drop", wrdy, 4'b0000);

        // Consumer 3 asks for read and write together: read first.
        ra[3] = 8'h33; wa[3] = 8'h34; wd[3] = 8'h99;
        rv[3] = 1'b1; wv[3] = 1'b1;
        wait_read_grant();
        check("rw_read_first", mwv, 1'b0);
        check("rw_read_addr", mra, 8'h33);
        reply_read(8'h77, 1);
        check("rw_read_ready", rrdy, 4'b1000);
        rv[3] = 1'b0;
        step();
        wait_write_grant();
        check("rw_write_no_read", mrv, 1'b0);
        check("rw_write_addr", mwa, 8'h34);
        reply_write(0);
        check("rw_write_ready", wrdy, 4'b1000);
        wv[3] = 1'b0;
        step();

        // Consumer 0 abandons its read; consumer 1 is served next.
        ra[0] = 8'h21; ra[1] = 8'h22; rv[0] = 1'b1; rv[1] = 1'b1;
        wait_read_grant();
        check("abandon_grant_addr", mra, 8'h21);
        rv[0] = 1'b0;
        step();
        reply_read(8'h5A, 1);
        check("abandon_no_ready", rrdy, 4'b0000);
        wait_read_grant();
        check("abandon_next_consumer", mra, 8'h22);
        reply_read(8'h6B, 0);
        check("abandon_next_ready", rrdy, 4'b0010);
        rv[1] = 1'b0;
        step();

        // Reset while a read is outstanding.
        ra[2] = 8'h44; rv[2] = 1'b1;
        wait_read_grant();
        #2 reset = 1'b0;
        #1 check("reset_midop_read_valid", mrv, 1'b0);
        rv = '0;
        step();
        #2 reset = 1'b1;
        ra[0] = 8'h55; ra[3] = 8'h56; rv[0] = 1'b1; rv[3] = 1'b1;
        wait_read_grant();
        check("post_reset_first_is_0", mra, 8'h55);
        reply_read(8'h66, 2);
        check("post_reset_ready", rrdy, 4'b0001);
        check("post_reset_data", rdata_flat[0*DW +: DW], 8'h66);
        check("post_reset_slice2_cleared", rdata_flat[2*DW +: DW], 8'h00);
        rv[0] = 1'b0;
        step();
        wait_read_grant();
        check("post_reset_second", mra, 8'h56);
        reply_read(8'h67, 0);
        rv[3] = 1'b0;
        step();

        // Randomized traffic.
        repeat (3000) begin
            step();
            randomize_inputs();
        end

        // Drain and confirm everything settles idle.
        rv = '0; wv = '0; mrr = 1'b1; mwr = 1'b1;
        repeat (10) step();
        check("drain_idle_valids", {mrv, mwv}, 2'b00);
        check("drain_idle_readies", {rrdy, wrdy}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
